// File: rtl/adv7513_pkg.sv
// adv7513_pkg: shared constants and types for the ADV7513 video timing block.
//   - RGB_W / CNT_W  : pixel data width and h/v counter width
//   - P720_* / P480_*: 1280x720p60 and 640x480p60 timing sets
//   - state_t        : sequencer state encoding
//   - bar_color()    : 8-bar colour lookup used by the optional test pattern
package adv7513_pkg;

    localparam int RGB_W = 24;
    localparam int CNT_W = 12;

    // 1280x720p60, 74.25 MHz pixel clock, positive syncs
    localparam int P720_H_ACTIVE = 1280;
    localparam int P720_H_FP     = 110;
    localparam int P720_H_SYNC   = 40;
    localparam int P720_H_BP     = 220;
    localparam int P720_V_ACTIVE = 720;
    localparam int P720_V_FP     = 5;
    localparam int P720_V_SYNC   = 5;
    localparam int P720_V_BP     = 20;

    // 640x480p60, 25.175 MHz pixel clock, negative syncs
    localparam int P480_H_ACTIVE = 640;
    localparam int P480_H_FP     = 16;
    localparam int P480_H_SYNC   = 96;
    localparam int P480_H_BP     = 48;
    localparam int P480_V_ACTIVE = 480;
    localparam int P480_V_FP     = 10;
    localparam int P480_V_SYNC   = 2;
    localparam int P480_V_BP     = 33;

    typedef enum logic [1:0] {
        s_idle  = 2'd0,
        s_run   = 2'd1,
        s_drain = 2'd2
    } state_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] bar);
        logic [RGB_W-1:0] c;
        case (bar)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/adv7513_sync_delay.sv
// adv7513_sync_delay: fixed-depth shift register with asynchronous clear.
// Used to delay the raw sync/enable bits (and, with the test pattern
// enabled, the pixel column) by the frame source's read latency.
//   clk   in          clock
//   reset in          asynchronous active-high clear of every stage
//   din   in  WIDTH   value entering the pipeline
//   dout  out WIDTH   din delayed by DEPTH clocks (DEPTH >= 1)
module adv7513_sync_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/adv7513_video_timing.sv
// adv7513_video_timing: parallel video timing generator for the ADV7513.
// Starts once the init stage raises enable, requests pixels by (x,y) from
// the frame source, absorbs PIXEL_LATENCY clocks of read latency and emits
// HS/VS/DE aligned to the returned RGB data.
//
// Optional build macro ADV7513_TEST_PATTERN_EN adds input test_mode, which
// replaces rgb_in with an internal 8-bar colour pattern.
//
// Ports:
//   clk          in   pixel clock
//   reset        in   asynchronous active-high reset
//   enable       in   level enable from the init stage
//   rgb_in       in   {R,G,B}, valid PIXEL_LATENCY clocks after pix_req
//   test_mode    in   (macro only) select colour bars
//   pix_req      out  pixel request, high in the active region
//   pix_x/pix_y  out  requested column/row, 0 when not requesting
//   frame_start  out  pulse with the first request of each frame
//   hdmi_d       out  RGB to the transmitter, 0 outside DE
//   hdmi_hs/vs   out  syncs, polarity set by HS_POL/VS_POL
//   hdmi_de      out  data enable
//   running      out  high while in s_run
//
// state   | meaning
// s_idle  | counters held at 0, nothing requested
// s_run   | counters free-run, frames generated continuously
// s_drain | finish the current frame, then flush PIXEL_LATENCY clocks
module adv7513_video_timing
    import adv7513_pkg::*;
#(
    parameter int   H_ACTIVE      = P720_H_ACTIVE,
    parameter int   H_FP          = P720_H_FP,
    parameter int   H_SYNC        = P720_H_SYNC,
    parameter int   H_BP          = P720_H_BP,
    parameter int   V_ACTIVE      = P720_V_ACTIVE,
    parameter int   V_FP          = P720_V_FP,
    parameter int   V_SYNC        = P720_V_SYNC,
    parameter int   V_BP          = P720_V_BP,
    parameter logic HS_POL        = 1'b1,
    parameter logic VS_POL        = 1'b1,
    parameter int   PIXEL_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [RGB_W-1:0] rgb_in,
`ifdef ADV7513_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic [RGB_W-1:0] hdmi_d,
    output logic             hdmi_hs,
    output logic             hdmi_vs,
    output logic             hdmi_de,
    output logic             running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]       FLUSH_INIT = 4'(PIXEL_LATENCY - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] h_cnt, v_cnt, h_nx, v_nx, h_adv, v_adv;
    logic             flushing, flush_nx;
    logic [3:0]       flush_cnt, flush_cnt_nx;
    logic             line_end, frame_end;
    logic             active, req_c, hs_c, vs_c;
    logic             raw_hs, raw_vs;
    logic             dly_hs, dly_vs, dly_de;
    logic [RGB_W-1:0] pix_data;

    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign h_adv     = line_end ? '0 : h_cnt + 1'b1;
    assign v_adv     = !line_end ? v_cnt : ((v_cnt == V_LAST) ? '0 : v_cnt + 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= s_idle;
            h_cnt     <= '0;
            v_cnt     <= '0;
            flushing  <= 1'b0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            h_cnt     <= h_nx;
            v_cnt     <= v_nx;
            flushing  <= flush_nx;
            flush_cnt <= flush_cnt_nx;
        end
    end

    // The flush is a sub-phase of s_drain: counters sit at 0 after the
    // frame wrap while the pipeline empties.
    always_comb begin
        state_nx     = state;
        h_nx         = h_cnt;
        v_nx         = v_cnt;
        flush_nx     = flushing;
        flush_cnt_nx = flush_cnt;
        case (state)
            s_idle: begin
                h_nx         = '0;
                v_nx         = '0;
                flush_nx     = 1'b0;
                flush_cnt_nx = '0;
                if (enable) state_nx = s_run;
            end
            s_run: begin
                h_nx = h_adv;
                v_nx = v_adv;
                if (!enable) begin
                    state_nx = s_drain;
                    // enable dropped on the very last clock of a frame
                    if (frame_end) begin
                        flush_nx     = 1'b1;
                        flush_cnt_nx = FLUSH_INIT;
                    end
                end
            end
            s_drain: begin
                if (flushing) begin
                    if (flush_cnt == '0) begin
                        state_nx = s_idle;
                        flush_nx = 1'b0;
                    end else begin
                        flush_cnt_nx = flush_cnt - 1'b1;
                    end
                end else begin
                    h_nx = h_adv;
                    v_nx = v_adv;
                    if (frame_end) begin
                        flush_nx     = 1'b1;
                        flush_cnt_nx = FLUSH_INIT;
                    end
                end
            end
            default: state_nx = s_idle;
        endcase
    end

    assign running = (state == s_run);

    assign active = (state != s_idle) && !flushing;
    assign req_c  = active && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_c   = active && (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs_c   = active && (v_cnt >= VS_START) && (v_cnt < VS_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_req     <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            raw_hs      <= 1'b0;
            raw_vs      <= 1'b0;
        end else begin
            pix_req     <= req_c;
            pix_x       <= req_c ? h_cnt : '0;
            pix_y       <= req_c ? v_cnt : '0;
            frame_start <= req_c && (h_cnt == '0) && (v_cnt == '0);
            raw_hs      <= hs_c;
            raw_vs      <= vs_c;
        end
    end

    // pix_req doubles as the raw DE; it leaves the delay line on the same
    // clock that rgb_in for that request is valid.
    adv7513_sync_delay #(
        .DEPTH (PIXEL_LATENCY),
        .WIDTH (3)
    ) u_sync_dly (
        .clk   (clk),
        .reset (reset),
        .din   ({raw_hs, raw_vs, pix_req}),
        .dout  ({dly_hs, dly_vs, dly_de})
    );

`ifdef ADV7513_TEST_PATTERN_EN
    logic [CNT_W-1:0] dly_x;
    logic [CNT_W+2:0] x_times8;
    logic [2:0]       bar_idx;

    adv7513_sync_delay #(
        .DEPTH (PIXEL_LATENCY),
        .WIDTH (CNT_W)
    ) u_x_dly (
        .clk   (clk),
        .reset (reset),
        .din   (pix_x),
        .dout  (dly_x)
    );

    assign x_times8 = {dly_x, 3'b000};
    assign bar_idx  = 3'(x_times8 / (CNT_W + 3)'(H_ACTIVE));
    assign pix_data = test_mode ? bar_color(bar_idx) : rgb_in;
`else
    assign pix_data = rgb_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdmi_hs <= ~HS_POL;
            hdmi_vs <= ~VS_POL;
            hdmi_de <= 1'b0;
            hdmi_d  <= '0;
        end else begin
            hdmi_hs <= dly_hs ? HS_POL : ~HS_POL;
            hdmi_vs <= dly_vs ? VS_POL : ~VS_POL;
            hdmi_de <= dly_de;
            hdmi_d  <= dly_de ? pix_data : '0;
        end
    end

endmodule

// File: tb/tb_adv7513_video_timing.sv
`timescale 1ns/1ps
module tb_adv7513_video_timing;

    localparam int LAT = 3;
    localparam int HA  = 8;
    localparam int VA  = 4;

    localparam int SIG_REQ = 0;
    localparam int SIG_FS  = 1;
    localparam int SIG_DE  = 2;
    localparam int SIG_HS  = 3;
    localparam int SIG_VS  = 4;
    localparam int SIG_RUN = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] rgb_in;
`ifdef ADV7513_TEST_PATTERN_EN
    logic        test_mode;
`endif
    logic        pix_req;
    logic [11:0] pix_x, pix_y;
    logic        frame_start;
    logic [23:0] hdmi_d;
    logic        hdmi_hs, hdmi_vs, hdmi_de;
    logic        running;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [23:0] exp_q [$];
    logic [23:0] sb_exp;

    adv7513_video_timing #(
        .H_ACTIVE(HA), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIXEL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .rgb_in(rgb_in),
`ifdef ADV7513_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .hdmi_d(hdmi_d), .hdmi_hs(hdmi_hs),
        .hdmi_vs(hdmi_vs), .hdmi_de(hdmi_de), .running(running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pix_f(input int x, input int y);
        return {8'(8'h10 + x * 3), 8'(8'h80 + y * 7), 8'(x ^ (y * 16) ^ 8'h5A)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic sig_now(input int which);
        case (which)
            SIG_REQ: return pix_req;
            SIG_FS:  return frame_start;
            SIG_DE:  return hdmi_de;
            SIG_HS:  return hdmi_hs;
            SIG_VS:  return hdmi_vs;
            default: return running;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int which, input logic level,
                            input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (sig_now(which) !== level && n < limit);
        if (sig_now(which) !== level) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout after %0d clocks", name, n);
        end
    endtask

    task automatic push_frames(input int nf);
        for (int f = 0; f < nf; f++)
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    exp_q.push_back(pix_f(x, y));
    endtask

    // Frame source model: answers each request LAT clocks later.
    bit       hist_req [LAT+1];
    int       hist_x   [LAT+1];
    int       hist_y   [LAT+1];
    initial begin
        for (int k = 0; k <= LAT; k++) begin
            hist_req[k] = 1'b0;
            hist_x[k]   = 0;
            hist_y[k]   = 0;
        end
        rgb_in = 24'hBADBAD;
    end
    always @(negedge clk) begin
        for (int k = LAT; k > 0; k--) begin
            hist_req[k] = hist_req[k-1];
            hist_x[k]   = hist_x[k-1];
            hist_y[k]   = hist_y[k-1];
        end
        hist_req[0] = pix_req;
        hist_x[0]   = int'(pix_x);
        hist_y[0]   = int'(pix_y);
        rgb_in = hist_req[LAT] ? pix_f(hist_x[LAT], hist_y[LAT]) : 24'hBADBAD;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (hdmi_de) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_de: hdmi_d=%h with no pixel expected", hdmi_d);
                end else begin
                    sb_exp = exp_q.pop_front();
                    chk("sb_pixel", 32'(hdmi_d), 32'(sb_exp));
                end
            end else begin
                chk("blank_d", 32'(hdmi_d), 32'd0);
            end
            if (!pix_req) chk("idle_xy", 32'({pix_x, pix_y}), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, cyc_a;
        reset  = 1'b1;
        enable = 1'b0;
`ifdef ADV7513_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ctrl", 32'({pix_req, frame_start, hdmi_de, running, hdmi_hs, hdmi_vs}), 32'd0);
        chk("rst_data", 32'(hdmi_d), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_quiet", 32'({pix_req, hdmi_de, running}), 32'd0);

        // frames 1 and 2 run fully, frame 3 is drained
        push_frames(3);
        enable = 1'b1;
        wait_sig("req_rise", SIG_REQ, 1'b1, 20, n);
        chk("req_latency", 32'(n), 32'd2);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_xy", 32'({pix_x, pix_y}), 32'd0);
        chk("running_on", 32'(running), 32'd1);
        wait_sig("de_rise", SIG_DE, 1'b1, 20, n);
        chk("de_latency", 32'(n), 32'(LAT + 1));
        chk("first_pixel", 32'(hdmi_d), 32'(pix_f(0, 0)));
        wait_sig("hs_rise", SIG_HS, 1'b1, 30, n);
        chk("hs_offset", 32'(n), 32'd10);
        wait_sig("hs_fall", SIG_HS, 1'b0, 30, n);
        chk("hs_width", 32'(n), 32'd2);
        wait_sig("vs_rise", SIG_VS, 1'b1, 100, n);
        chk("vs_offset", 32'(n), 32'd58);
        wait_sig("vs_fall", SIG_VS, 1'b0, 30, n);
        chk("vs_width", 32'(n), 32'd14);
        wait_sig("fs2", SIG_FS, 1'b1, 120, n);
        chk("fs2_offset", 32'(n), 32'd10);
        cyc_a = cyc;
        wait_sig("fs_pulse", SIG_FS, 1'b0, 5, n);
        chk("fs_width", 32'(n), 32'd1);
        wait_sig("fs3", SIG_FS, 1'b1, 120, n);
        chk("frame_period", 32'(cyc - cyc_a), 32'd98);

        // drop enable on line 2, column 3 of frame 3
        repeat (30) @(negedge clk);
        chk("running_before_drop", 32'(running), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("run_fall", 32'(running), 32'd0);
        cnt = pix_req ? 1 : 0;
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            if (pix_req) cnt++;
        end
        chk("drain_req_count", 32'(cnt), 32'd13);
        chk("drain_all_out", 32'(exp_q.size()), 32'd0);
        chk("idle_after_drain", 32'(running), 32'd0);

        // re-enable during drain: frame A completes, flushes, B restarts
        push_frames(2);
        enable = 1'b1;
        wait_sig("fsA", SIG_FS, 1'b1, 20, n);
        chk("reen_latency", 32'(n), 32'd2);
        cyc_a = cyc;
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("drain_not_running", 32'(running), 32'd0);
        enable = 1'b1;
        wait_sig("fsB", SIG_FS, 1'b1, 150, n);
        chk("restart_period", 32'(cyc - cyc_a), 32'(98 + LAT + 1));
        chk("restart_xy", 32'({pix_x, pix_y}), 32'd0);
        chk("restart_running", 32'(running), 32'd1);

        // asynchronous reset in the middle of an active line
        wait_sig("deB", SIG_DE, 1'b1, 20, n);
        chk("deB_latency", 32'(n), 32'(LAT + 1));
        repeat (2) @(negedge clk);
        chk("deB_mid", 32'(hdmi_de), 32'd1);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({pix_req, frame_start, hdmi_de, running, hdmi_hs, hdmi_vs}), 32'd0);
        chk("mid_rst_data", 32'(hdmi_d), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (pix_req || hdmi_de) cnt++;
        end
        chk("post_rst_quiet", 32'(cnt), 32'd0);

`ifdef ADV7513_TEST_PATTERN_EN
        begin
            logic [23:0] bars [8];
            bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00;
            bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
            bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000;
            bars[6] = 24'h0000FF; bars[7] = 24'h000000;
            // H_ACTIVE = 8, so each bar is one pixel wide
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    exp_q.push_back(bars[x]);
            test_mode = 1'b1;
            enable    = 1'b1;
            wait_sig("fs_tp", SIG_FS, 1'b1, 20, n);
            repeat (40) @(negedge clk);
            enable = 1'b0;
            repeat (200) @(negedge clk);
            chk("tp_all_out", 32'(exp_q.size()), 32'd0);
            test_mode = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
